rom_load_arbiter: RTL and testbench

- Shares the single-port cartridge ROM RAM between two requesters: the SPI file-download writer (byte strobe, address, data) and the console CPU read port.
- Sequences the load:
  - holds the CPU in reset during a download and for a fixed hold-off afterwards;
  - buffers each downloaded byte until the RAM is free;
  - tracks loaded ROM size.
- Sits between the download front end, the Z80 bus logic and the RAM.

---
 rtl/rom_load_arbiter_if.sv | 46 ++++
 rtl/rom_load_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_load_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_load_arbiter_if.sv
// rtl/rom_load_arbiter_if.sv - download, CPU and RAM bus bundle for rom_load_arbiter (ROM_LOAD_CHECKSUM_EN adds rom_sum)
interface rom_load_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              dl_downloading;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_a;
  logic [7:0]        dl_d;
  logic              cpu_rd_req;
  logic [ADDR_W-1:0] cpu_a;
  logic [7:0]        cpu_rd_data;
  logic              cpu_ack;
  logic              cpu_reset;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_d;
  logic              ram_we;
  logic              ram_oe;
  logic [7:0]        ram_q;
  logic [ADDR_W:0]   rom_size;
  logic              overrun;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0]        rom_sum;

  modport master (
    output dl_downloading, dl_wr, dl_a, dl_d, cpu_rd_req, cpu_a, ram_q,
    input  cpu_rd_data, cpu_ack, cpu_reset, ram_a, ram_d, ram_we, ram_oe,
           rom_size, overrun, rom_sum
  );
  modport slave (
    input  dl_downloading, dl_wr, dl_a, dl_d, cpu_rd_req, cpu_a, ram_q,
    output cpu_rd_data, cpu_ack, cpu_reset, ram_a, ram_d, ram_we, ram_oe,
           rom_size, overrun, rom_sum
  );
`else
  modport master (
    output dl_downloading, dl_wr, dl_a, dl_d, cpu_rd_req, cpu_a, ram_q,
    input  cpu_rd_data, cpu_ack, cpu_reset, ram_a, ram_d, ram_we, ram_oe,
           rom_size, overrun
  );
  modport slave (
    input  dl_downloading, dl_wr, dl_a, dl_d, cpu_rd_req, cpu_a, ram_q,
    output cpu_rd_data, cpu_ack, cpu_reset, ram_a, ram_d, ram_we, ram_oe,
           rom_size, overrun
  );
`endif
endinterface

// File: rtl/rom_load_arbiter.sv
// rtl/rom_load_arbiter.sv - shares the cartridge ROM RAM between SPI download writes and CPU reads
// Optional ROM_LOAD_CHECKSUM_EN adds rom_sum, the mod-256 sum of committed bytes.
module rom_load_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int RAM_LAT    = 2,
  parameter int RESET_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  rom_load_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state, state_nxt;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_a;
  logic [7:0]        pend_d;
  logic [2:0]        lat_cnt, lat_nxt;
  logic [7:0]        hold_cnt;
  logic              dl_prev;
  logic              dl_take, dl_rise, consume;
  logic [ADDR_W:0]   wr_end;

  logic              ram_we_nxt, ram_oe_nxt, cpu_ack_nxt;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic [7:0]        ram_d_nxt, rd_data_nxt;
  logic [ADDR_W:0]   rom_size_nxt;

  assign dl_take = bus.dl_wr && bus.dl_downloading;
  assign dl_rise = bus.dl_downloading && !dl_prev;
  assign consume = (state == WRITE);
  assign wr_end  = {1'b0, bus.ram_a} + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      lat_cnt         <= 3'd0;
      bus.ram_we      <= 1'b0;
      bus.ram_oe      <= 1'b0;
      bus.ram_a       <= '0;
      bus.ram_d       <= 8'd0;
      bus.cpu_ack     <= 1'b0;
      bus.cpu_rd_data <= 8'd0;
      bus.rom_size    <= '0;
    end else begin
      state           <= state_nxt;
      lat_cnt         <= lat_nxt;
      bus.ram_we      <= ram_we_nxt;
      bus.ram_oe      <= ram_oe_nxt;
      bus.ram_a       <= ram_a_nxt;
      bus.ram_d       <= ram_d_nxt;
      bus.cpu_ack     <= cpu_ack_nxt;
      bus.cpu_rd_data <= rd_data_nxt;
      bus.rom_size    <= rom_size_nxt;
    end
  end

  // Pending writes beat CPU reads; a read in flight always runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pend_valid)
          state_nxt = WRITE;
        else if (bus.cpu_rd_req && !bus.cpu_reset)
          state_nxt = READ;
      end
      WRITE:   state_nxt = IDLE;
      READ:    if (lat_cnt == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_we_nxt   = (state_nxt == WRITE);
    ram_oe_nxt   = (state_nxt == READ);
    ram_a_nxt    = bus.ram_a;
    ram_d_nxt    = bus.ram_d;
    cpu_ack_nxt  = 1'b0;
    rd_data_nxt  = bus.cpu_rd_data;
    lat_nxt      = lat_cnt;
    rom_size_nxt = bus.rom_size;
    if (state == IDLE && state_nxt == WRITE) begin
      ram_a_nxt = pend_a;
      ram_d_nxt = pend_d;
    end
    if (state == IDLE && state_nxt == READ) begin
      ram_a_nxt = bus.cpu_a;
      lat_nxt   = 3'(RAM_LAT);
    end
    if (state == READ) begin
      lat_nxt = lat_cnt - 3'd1;
      if (lat_cnt == 3'd1) begin
        rd_data_nxt = bus.ram_q;
        cpu_ack_nxt = 1'b1;
      end
    end
    if (dl_rise)
      rom_size_nxt = '0;
    else if (state == WRITE && wr_end > bus.rom_size)
      rom_size_nxt = wr_end;
  end

  // A new byte landing on the edge that drains the buffer is not an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid  <= 1'b0;
      pend_a      <= '0;
      pend_d      <= 8'd0;
      bus.overrun <= 1'b0;
      dl_prev     <= 1'b0;
    end else begin
      dl_prev <= bus.dl_downloading;
      if (dl_take) begin
        pend_a     <= bus.dl_a;
        pend_d     <= bus.dl_d;
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (dl_rise)
        bus.overrun <= 1'b0;
      else if (dl_take && pend_valid && !consume)
        bus.overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt      <= 8'(RESET_HOLD);
      bus.cpu_reset <= 1'b1;
    end else if (bus.dl_downloading) begin
      hold_cnt      <= 8'(RESET_HOLD);
      bus.cpu_reset <= 1'b1;
    end else if (hold_cnt != 8'd0) begin
      hold_cnt      <= hold_cnt - 8'd1;
      bus.cpu_reset <= (hold_cnt != 8'd1);
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.rom_sum <= 8'd0;
    else if (dl_rise)
      bus.rom_sum <= 8'd0;
    else if (state == WRITE)
      bus.rom_sum <= bus.rom_sum + bus.ram_d;
  end
`endif
endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb/tb_rom_load_arbiter.sv - randomized self-checking bench for rom_load_arbiter against a ROM-image model
module tb_rom_load_arbiter;
  localparam int ADDR_W     = 16;
  localparam int RAM_LAT    = 2;
  localparam int RESET_HOLD = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  rom_load_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  rom_load_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .RESET_HOLD(RESET_HOLD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535] = '{default: 8'h00};
  logic [7:0]  img [0:65535] = '{default: 8'h00};
  logic [23:0] exp_wq [$];
  int          exp_size = 0;
  int          exp_sum = 0;
  logic        we_prev = 1'b0;

  assign bus.ram_q = bus.ram_oe ? mem[bus.ram_a] : 8'h00;
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the next byte the bench expects to be committed.
  always @(negedge clk) begin
    if (reset_n && bus.ram_we) begin
      if (exp_wq.size() == 0) begin
        check("unexpected_write", {8'h00, bus.ram_a, bus.ram_d}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] w;
        w = exp_wq.pop_front();
        check("write_addr", {16'h0, bus.ram_a}, {16'h0, w[23:8]});
        check("write_data", {24'h0, bus.ram_d}, {24'h0, w[7:0]});
      end
      check("we_single_cycle", {31'h0, we_prev}, 32'h0);
    end
    we_prev <= bus.ram_we;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dl_byte(input logic [15:0] a, input logic [7:0] d, input int gap);
    bus.dl_a  = a;
    bus.dl_d  = d;
    bus.dl_wr = 1'b1;
    exp_wq.push_back({a, d});
    img[a]   = d;
    exp_size = (int'(a) + 1 > exp_size) ? int'(a) + 1 : exp_size;
    exp_sum  = (exp_sum + int'(d)) % 256;
    tick();
    bus.dl_wr = 1'b0;
    check("we_not_early", {31'h0, bus.ram_we}, 32'h0);
    tick();
    check("we_two_after_strobe", {31'h0, bus.ram_we}, 32'h1);
    repeat (gap) tick();
  endtask

  task automatic download_start();
    bus.dl_downloading = 1'b1;
    exp_size = 0;
    exp_sum  = 0;
    tick();
    check("start_overrun_clear", {31'h0, bus.overrun}, 32'h0);
    check("start_cpu_reset", {31'h0, bus.cpu_reset}, 32'h1);
  endtask

  task automatic download_end();
    int k;
    k = 0;
    bus.dl_downloading = 1'b0;
    do begin
      tick();
      k++;
    end while (bus.cpu_reset && k < 300);
    check("hold_off_cycles", k, RESET_HOLD);
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    int k, oe;
    k  = 0;
    oe = 0;
    bus.cpu_a      = a;
    bus.cpu_rd_req = 1'b1;
    do begin
      tick();
      k++;
      if (bus.ram_oe) oe++;
    end while (!bus.cpu_ack && k < 50);
    bus.cpu_rd_req = 1'b0;
    check({tag, "_ack_lat"}, k, RAM_LAT + 1);
    check({tag, "_oe_cycles"}, oe, RAM_LAT);
    check({tag, "_data"}, {24'h0, bus.cpu_rd_data}, {24'h0, img[a]});
    tick();
    check({tag, "_ack_pulse"}, {31'h0, bus.cpu_ack}, 32'h0);
  endtask

  initial begin
    int k, oe_seen;
    logic [15:0] addrs [$];

    bus.dl_downloading = 1'b0;
    bus.dl_wr          = 1'b0;
    bus.dl_a           = '0;
    bus.dl_d           = 8'h00;
    bus.cpu_rd_req     = 1'b0;
    bus.cpu_a          = '0;

    repeat (3) tick();
    check("rst_cpu_reset", {31'h0, bus.cpu_reset}, 32'h1);
    check("rst_strobes", {28'h0, bus.ram_we, bus.ram_oe, bus.cpu_ack, bus.overrun}, 32'h0);
    check("rst_ram_bus", {8'h0, bus.ram_a, bus.ram_d}, 32'h0);
    check("rst_rd_data", {24'h0, bus.cpu_rd_data}, 32'h0);
    check("rst_rom_size", {15'h0, bus.rom_size}, 32'h0);

    // Reads requested during the hold-off must not be accepted.
    bus.cpu_rd_req = 1'b1;
    reset_n = 1'b1;
    k = 0;
    oe_seen = 0;
    do begin
      tick();
      k++;
      if (bus.ram_oe) oe_seen++;
    end while (bus.cpu_reset && k < 300);
    bus.cpu_rd_req = 1'b0;
    check("release_hold_cycles", k, RESET_HOLD);
    check("no_read_in_reset", oe_seen, 0);

    download_start();
    dl_byte(16'h0000, 8'h3C, 14);
    dl_byte(16'h0001, 8'hA5, 14);
    dl_byte(16'h0002, 8'h7E, 14);
    check("dl3_rom_size", {15'h0, bus.rom_size}, 32'd3);
    check("dl3_overrun", {31'h0, bus.overrun}, 32'h0);
    download_end();

    do_read(16'h0001, "rd_a5");
    do_read(16'h0000, "rd_3c");

    // Request held through the ack cycle issues a second read.
    bus.cpu_a      = 16'h0002;
    bus.cpu_rd_req = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!bus.cpu_ack && k < 50);
    check("b2b_first_lat", k, RAM_LAT + 1);
    tick();
    bus.cpu_rd_req = 1'b0;
    check("b2b_second_issued", {31'h0, bus.ram_oe}, 32'h1);
    k = 1;
    do begin tick(); k++; end while (!bus.cpu_ack && k < 50);
    check("b2b_second_lat", k, RAM_LAT + 1);
    check("b2b_second_data", {24'h0, bus.cpu_rd_data}, 32'h7E);
    tick();

    // Two strobes one cycle apart while a read is in flight: only the second byte survives.
    bus.cpu_a      = 16'h0002;
    bus.cpu_rd_req = 1'b1;
    tick();
    bus.dl_downloading = 1'b1;
    bus.dl_wr = 1'b1;
    bus.dl_a  = 16'h0100;
    bus.dl_d  = 8'h11;
    tick();
    bus.dl_a  = 16'h0200;
    bus.dl_d  = 8'h22;
    tick();
    bus.dl_wr = 1'b0;
    check("ovr_read_ack", {31'h0, bus.cpu_ack}, 32'h1);
    check("ovr_read_data", {24'h0, bus.cpu_rd_data}, 32'h7E);
    bus.cpu_rd_req = 1'b0;
    check("ovr_flag", {31'h0, bus.overrun}, 32'h1);
    exp_wq.push_back({16'h0200, 8'h22});
    img[16'h0200] = 8'h22;
    repeat (4) tick();
    check("ovr_rom_size", {15'h0, bus.rom_size}, 32'h201);
    check("ovr_flag_sticky", {31'h0, bus.overrun}, 32'h1);
`ifdef ROM_LOAD_CHECKSUM_EN
    check("ovr_rom_sum", {24'h0, bus.rom_sum}, 32'h22);
`endif
    download_end();
    do_read(16'h0100, "rd_lost");
    do_read(16'h0200, "rd_kept");

    download_start();
    dl_byte(16'hFFFF, 8'hFF, 2);
    dl_byte(16'h0010, 8'h02, 2);
    check("top_rom_size", {15'h0, bus.rom_size}, 32'h10000);
`ifdef ROM_LOAD_CHECKSUM_EN
    check("top_rom_sum", {24'h0, bus.rom_sum}, 32'h01);
`endif
    download_end();
    do_read(16'hFFFF, "rd_ffff");

    for (int r = 0; r < 4; r++) begin
      int n;
      addrs.delete();
      download_start();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        logic [15:0] a;
        a = 16'($urandom);
        addrs.push_back(a);
        dl_byte(a, 8'($urandom), $urandom_range(0, 4));
      end
      tick();
      check("rnd_rom_size", {15'h0, bus.rom_size}, exp_size);
      check("rnd_overrun", {31'h0, bus.overrun}, 32'h0);
`ifdef ROM_LOAD_CHECKSUM_EN
      check("rnd_rom_sum", {24'h0, bus.rom_sum}, exp_sum);
`endif
      download_end();
      for (int i = 0; i < 4; i++)
        do_read(addrs[$urandom_range(0, addrs.size() - 1)], "rnd_rd");
      do_read(16'($urandom), "rnd_rd_any");
    end

    repeat (4) tick();
    check("write_queue_empty", exp_wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
